// File: rtl/adder_421_pkg.sv
// Shared definitions for the 4:2:1 adder result checker.
//   chk_state_e : run-control states of the checker
//   sum_width() : width of the golden sum / DUT result for a given operand width
package adder_421_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } chk_state_e;

    // Four W-bit operands plus two carry bits never exceed 2^(W+2)-2.
    function automatic int sum_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/adder_421_ref_pipe.sv
// Golden-sum reference pipeline for the 4:2:1 adder checker.
// Computes c0+c1+c2+c3+cy0+cy1 and delays it, together with a valid bit,
// through LATENCY register stages so it lines up with the DUT output.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears valids only)
//   load                operands on c0..c3/cy0/cy1 enter stage 0 this cycle
//   c0..c3, cy0, cy1    operands, same values presented to the DUT
//   exp_valid, exp_sum  last stage: expected result due from the DUT now
//   empty               no valid sample anywhere in the delay line
module adder_421_ref_pipe
    import adder_421_pkg::*;
#(
    parameter int IN_WIDTH = 9,
    parameter int LATENCY  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [IN_WIDTH-1:0]            c0,
    input  logic [IN_WIDTH-1:0]            c1,
    input  logic [IN_WIDTH-1:0]            c2,
    input  logic [IN_WIDTH-1:0]            c3,
    input  logic                           cy0,
    input  logic                           cy1,
    output logic                           exp_valid,
    output logic [sum_width(IN_WIDTH)-1:0] exp_sum,
    output logic                           empty
);

    localparam int SW = sum_width(IN_WIDTH);

    logic [SW-1:0]               sum_next;
    logic [LATENCY-1:0]          valid_reg;
    logic [LATENCY-1:0]          valid_next;
    logic [LATENCY-1:0][SW-1:0]  data_reg;
    logic [LATENCY-1:0][SW-1:0]  data_next;

    // Zero-extend before adding so no carry is lost.
    assign sum_next = SW'(c0) + SW'(c1) + SW'(c2) + SW'(c3) + SW'(cy0) + SW'(cy1);

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = load;
                assign data_next[gi]  = sum_next;
            end else begin : g_tail
                assign valid_next[gi] = valid_reg[gi-1];
                assign data_next[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    // Data needs no reset: it is only looked at when its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
        data_reg <= data_next;
    end

    assign exp_valid = valid_reg[LATENCY-1];
    assign exp_sum   = data_reg[LATENCY-1];
    assign empty     = ~|valid_reg;

endmodule

// File: rtl/adder_421_checker.sv
// Result-side checker for the 4:2:1 adder hardware-evaluation harness.
// Recomputes the golden sum of the operands sent to the DUT, aligns it to
// the DUT latency and compares against dut_o; counts samples and mismatches.
// Optional build macro: ADDER_421_CHK_CAPTURE_EN adds first_exp/first_got/
// first_idx, which hold the first mismatch of the run.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             pulse: clear counters and begin a run (IDLE/DONE only)
//   stop              pulse: end the run once in-flight samples drain (RUN only)
//   in_valid          operands are presented to the DUT this cycle
//   C0..C3, CY0, CY1  operands and carry-ins, same values the DUT sees
//   dut_o             DUT result
//   busy / done       run in progress / run finished
//   fail              sticky: at least one mismatch this run
//   sample_cnt        compared samples (wraps)
//   err_cnt           mismatches (saturates)
//   first_exp/got/idx first mismatch: expected, actual, 0-based sample index
module adder_421_checker
    import adder_421_pkg::*;
#(
    parameter int IN_WIDTH  = 9,
    parameter int LATENCY   = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           in_valid,
    input  logic [IN_WIDTH-1:0]            C0,
    input  logic [IN_WIDTH-1:0]            C1,
    input  logic [IN_WIDTH-1:0]            C2,
    input  logic [IN_WIDTH-1:0]            C3,
    input  logic                           CY0,
    input  logic                           CY1,
    input  logic [sum_width(IN_WIDTH)-1:0] dut_o,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [CNT_WIDTH-1:0]           sample_cnt,
`ifdef ADDER_421_CHK_CAPTURE_EN
    output logic [sum_width(IN_WIDTH)-1:0] first_exp,
    output logic [sum_width(IN_WIDTH)-1:0] first_got,
    output logic [CNT_WIDTH-1:0]           first_idx,
`endif
    output logic [CNT_WIDTH-1:0]           err_cnt
);

    localparam int SW = sum_width(IN_WIDTH);

    chk_state_e           state_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 fail_reg;
    logic [CNT_WIDTH-1:0] sample_cnt_reg;
    logic [CNT_WIDTH-1:0] err_cnt_reg;

    logic                 accept;
    logic                 go_arm;
    logic                 exp_valid;
    logic [SW-1:0]        exp_sum;
    logic                 pipe_empty;
    logic                 mismatch;

    // Operands only enter the delay line while a run is accepting them.
    assign accept   = in_valid && (state_reg == ARM || state_reg == RUN);
    assign go_arm   = start && (state_reg == IDLE || state_reg == DONE);
    assign mismatch = exp_valid && (dut_o != exp_sum);

    adder_421_ref_pipe #(
        .IN_WIDTH (IN_WIDTH),
        .LATENCY  (LATENCY)
    ) u_ref_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .c0        (C0),
        .c1        (C1),
        .c2        (C2),
        .c3        (C3),
        .cy0       (CY0),
        .cy1       (CY1),
        .exp_valid (exp_valid),
        .exp_sum   (exp_sum),
        .empty     (pipe_empty)
    );

    // Run control. busy/done are registered alongside the state so they
    // change on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // start beats a simultaneous stop here
                    if (start) begin
                        state_reg <= ARM;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                ARM: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Counters clear on the edge that enters ARM, so they read zero while
    // ARM is active. The delay line is always empty in IDLE/DONE, so a clear
    // can never collide with a comparison.
    always_ff @(posedge clk) begin
        if (!rst_n || go_arm) begin
            sample_cnt_reg <= '0;
            err_cnt_reg    <= '0;
            fail_reg       <= 1'b0;
        end else if (exp_valid) begin
            sample_cnt_reg <= sample_cnt_reg + CNT_WIDTH'(1);
            if (mismatch) begin
                fail_reg <= 1'b1;
                if (err_cnt_reg != {CNT_WIDTH{1'b1}}) begin
                    err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef ADDER_421_CHK_CAPTURE_EN
    logic [SW-1:0]        first_exp_reg;
    logic [SW-1:0]        first_got_reg;
    logic [CNT_WIDTH-1:0] first_idx_reg;

    // fail_reg still low means this is the first mismatch of the run; the
    // index is the count of samples compared before it.
    always_ff @(posedge clk) begin
        if (!rst_n || go_arm) begin
            first_exp_reg <= '0;
            first_got_reg <= '0;
            first_idx_reg <= '0;
        end else if (mismatch && !fail_reg) begin
            first_exp_reg <= exp_sum;
            first_got_reg <= dut_o;
            first_idx_reg <= sample_cnt_reg;
        end
    end

    assign first_exp = first_exp_reg;
    assign first_got = first_got_reg;
    assign first_idx = first_idx_reg;
`endif

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fail       = fail_reg;
    assign sample_cnt = sample_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_adder_421_checker.sv
// Self-checking bench for adder_421_checker. A second instance with a 4-bit
// counter width shares all stimulus to exercise wrap and saturation.
module tb_adder_421_checker;

    localparam int W  = 9;
    localparam int L  = 2;
    localparam int SW = W + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          in_valid;
    logic [W-1:0]  c0, c1, c2, c3;
    logic          cy0, cy1;
    logic [SW-1:0] dut_o;

    logic          busy, done, fail;
    logic [31:0]   sample_cnt, err_cnt;
    logic          busy4, done4, fail4;
    logic [3:0]    sample_cnt4, err_cnt4;
`ifdef ADDER_421_CHK_CAPTURE_EN
    logic [SW-1:0] first_exp, first_got, first_exp4, first_got4;
    logic [31:0]   first_idx;
    logic [3:0]    first_idx4;
`endif

    always #5 clk = ~clk;

    adder_421_checker #(.IN_WIDTH(W), .LATENCY(L), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .C0(c0), .C1(c1), .C2(c2), .C3(c3), .CY0(cy0), .CY1(cy1), .dut_o(dut_o),
        .busy(busy), .done(done), .fail(fail), .sample_cnt(sample_cnt),
`ifdef ADDER_421_CHK_CAPTURE_EN
        .first_exp(first_exp), .first_got(first_got), .first_idx(first_idx),
`endif
        .err_cnt(err_cnt)
    );

    adder_421_checker #(.IN_WIDTH(W), .LATENCY(L), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .C0(c0), .C1(c1), .C2(c2), .C3(c3), .CY0(cy0), .CY1(cy1), .dut_o(dut_o),
        .busy(busy4), .done(done4), .fail(fail4), .sample_cnt(sample_cnt4),
`ifdef ADDER_421_CHK_CAPTURE_EN
        .first_exp(first_exp4), .first_got(first_got4), .first_idx(first_idx4),
`endif
        .err_cnt(err_cnt4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [31:0] samp;
        logic [31:0] errs;
        logic        fl;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            m_samp;
    int            m_err;
    logic          m_fail;
    logic [SW-1:0] hist0 = '0;
    logic [SW-1:0] hist1 = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pop every expectation whose comparing edge has just passed.
    always @(posedge clk) begin
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            $display("sample %0d: sample_cnt=%0d err_cnt=%0d fail=%0d", mon_e.samp, sample_cnt, err_cnt, fail);
            check_eq("sb_sample_cnt", sample_cnt, mon_e.samp);
            check_eq("sb_err_cnt", err_cnt, mon_e.errs);
            check_eq("sb_fail", fail, mon_e.fl);
        end
    end

    // One clock cycle. Called at a negedge; drives operands, presents the DUT
    // result that belongs to the operands of two calls earlier (DUT latency 2),
    // optionally records the expected counter state after the comparison.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic x, input logic y, input int delta, input logic push);
        logic [SW-1:0] s;
        in_valid = v; c0 = a; c1 = b; c2 = c; c3 = d; cy0 = x; cy1 = y;
        s = SW'(a) + SW'(b) + SW'(c) + SW'(d) + SW'(x) + SW'(y);
        dut_o = hist1;
        hist1 = hist0;
        hist0 = v ? (s + SW'(delta)) : '0;
        if (v && push) begin
            m_samp++;
            if (delta != 0) begin
                m_err++;
                m_fail = 1'b1;
            end
            sb_q.push_back('{cyc + 3, 32'(m_samp), 32'(m_err), m_fail});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle();
        start = 1'b0;
        m_samp = 0; m_err = 0; m_fail = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        idle();
        stop = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) idle();
        check_eq(tag, done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        m_samp = 0; m_err = 0; m_fail = 1'b0;
        @(negedge clk);
        idle(); idle();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_fail", fail, 1'b0);
        check_eq("rst_sample_cnt", sample_cnt, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        idle();

        // 1: random clean run
        pulse_start();
        check_eq("t1_busy_arm", busy, 1'b1);
        for (int i = 0; i < 100; i++)
            drive(1'b1, W'($urandom_range(0, 511)), W'($urandom_range(0, 511)),
                  W'($urandom_range(0, 511)), W'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b1);
        pulse_stop();
        wait_done("t1_done");
        check_eq("t1_sample_cnt", sample_cnt, 100);
        check_eq("t1_err_cnt", err_cnt, 0);
        check_eq("t1_fail", fail, 1'b0);
        check_eq("t1_busy", busy, 1'b0);

        // 2: maximum operands, then a single mismatch
        pulse_start();
        check_eq("t2_cleared", sample_cnt, 0);
        check_eq("t2_done_clr", done, 1'b0);
        drive(1'b1, 9'd511, 9'd511, 9'd511, 9'd511, 1'b1, 1'b1, 0, 1'b1);
        drive(1'b1, 9'd511, 9'd511, 9'd511, 9'd511, 1'b1, 1'b1, -1, 1'b1);
        idle(); idle();
        check_eq("t2_err_cnt", err_cnt, 1);
        check_eq("t2_fail", fail, 1'b1);
        pulse_stop();
        wait_done("t2_done");

        // 3: stop with two samples in flight; in_valid during drain ignored
        pulse_start();
        drive(1'b1, 9'd10, 9'd20, 9'd30, 9'd40, 1'b0, 1'b1, 0, 1'b1);
        drive(1'b1, 9'd100, 9'd200, 9'd300, 9'd400, 1'b1, 1'b0, 0, 1'b1);
        pulse_stop();
        check_eq("t3_busy_drain", busy, 1'b1);
        drive(1'b1, 9'd5, 9'd5, 9'd5, 9'd5, 1'b0, 1'b0, 7, 1'b0);
        drive(1'b1, 9'd6, 9'd6, 9'd6, 9'd6, 1'b0, 1'b0, 7, 1'b0);
        wait_done("t3_done");
        idle(); idle();
        check_eq("t3_sample_cnt", sample_cnt, 2);
        check_eq("t3_err_cnt", err_cnt, 0);

        // 4: reset mid-run, in-flight samples discarded
        pulse_start();
        drive(1'b1, 9'd1, 9'd2, 9'd3, 9'd4, 1'b0, 1'b0, 1, 1'b0);
        drive(1'b1, 9'd5, 9'd6, 9'd7, 9'd8, 1'b0, 1'b0, 1, 1'b0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        check_eq("t4_busy", busy, 1'b0);
        check_eq("t4_done", done, 1'b0);
        check_eq("t4_sample_cnt", sample_cnt, 0);
        for (int i = 0; i < 4; i++) idle();
        check_eq("t4_late_sample", sample_cnt, 0);
        check_eq("t4_late_err", err_cnt, 0);
        check_eq("t4_fail", fail, 1'b0);
        check_eq("t4_idle_busy", busy, 1'b0);

        // 5: twenty forced mismatches; narrow instance saturates and wraps
        pulse_start();
        for (int i = 0; i < 20; i++)
            drive(1'b1, W'(i * 7), W'(i), 9'd3, 9'd0, 1'b1, 1'b0, 1, 1'b1);
        pulse_stop();
        wait_done("t5_done");
        check_eq("t5_err_cnt", err_cnt, 20);
        check_eq("t5_err_cnt4", err_cnt4, 15);
        check_eq("t5_sample_cnt4", sample_cnt4, 4);
        check_eq("t5_fail4", fail4, 1'b1);

`ifdef ADDER_421_CHK_CAPTURE_EN
        // 6: first-mismatch capture, retained past later mismatches
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (i == 7)
                drive(1'b1, 9'd300, 9'd0, 9'd0, 9'd0, 1'b0, 1'b0, 1, 1'b1);
            else
                drive(1'b1, W'($urandom_range(0, 511)), 9'd1, 9'd2, 9'd3, 1'b0, 1'b1,
                      (i == 9) ? 2 : 0, 1'b1);
        end
        pulse_stop();
        wait_done("t6_done");
        check_eq("t6_first_idx", first_idx, 7);
        check_eq("t6_first_exp", first_exp, 300);
        check_eq("t6_first_got", first_got, 301);
        pulse_start();
        check_eq("t6_clr_idx", first_idx, 0);
        check_eq("t6_clr_exp", first_exp, 0);
        check_eq("t6_clr_got", first_got, 0);
        pulse_stop();
        wait_done("t6_done2");
`endif

        idle(); idle(); idle();
        check_eq("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
